// File: rtl/key_event_unit.sv
// Four-lane button front end: synchronize, debounce, track hold time and
// queue press/release events with chart timestamps in a 4-entry FIFO.
module key_event_unit #(
  parameter logic [15:0] DB_CYCLES = 16'd20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key0,
  input  logic        key1,
  input  logic        key2,
  input  logic        key3,
  input  logic [15:0] timecnt,
  output logic [3:0]  key_state,
  output logic [63:0] hold_cnt,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [1:0]  evt_key,
  output logic        evt_type,
  output logic [15:0] evt_time,
  output logic        overflow
);

  localparam int unsigned NK    = 4;
  localparam int unsigned CW    = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PW    = 2;
  localparam int unsigned OW    = 3;

  typedef struct packed {
    logic [1:0]  key;
    logic        kind;
    logic [15:0] tstamp;
  } evt_t;

  logic [NK-1:0]         sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NK-1:0]         ks_q, ks_d, tgl;
  logic [NK-1:0][CW-1:0] cnt_q, cnt_d, hold_q, hold_d;
  evt_t [DEPTH-1:0]      mem_q, mem_d;
  logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [OW-1:0]         occ_q, occ_d, free_slots, n_wr;
  logic                  ovf_q, ovf_d, pop;
  evt_t                  head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      ks_q    <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      mem_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      occ_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      ks_q    <= ks_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      occ_q   <= occ_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    sync1_d = {key3, key2, key1, key0};
    sync2_d = sync1_q;
  end

  // Debounce qualification and hold-duration tracking per lane
  always_comb begin
    ks_d   = ks_q;
    cnt_d  = cnt_q;
    hold_d = hold_q;
    tgl    = '0;
    for (int i = 0; i < NK; i++) begin
      if (sync2_q[i] == ks_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_CYCLES - 16'd1) begin
        cnt_d[i] = '0;
        ks_d[i]  = ~ks_q[i];
        tgl[i]   = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
      if (tgl[i] && !ks_q[i]) begin
        hold_d[i] = '0;
      end else if (ks_q[i] && hold_q[i] != 16'hFFFF) begin
        hold_d[i] = hold_q[i] + 16'd1;
      end
    end
  end

  // Event FIFO: lanes enqueue in ascending order, surplus events are dropped
  always_comb begin
    mem_d      = mem_q;
    ovf_d      = ovf_q;
    pop        = (occ_q != 3'd0) && evt_ready;
    free_slots = OW'(3'd4 - occ_q) + {2'b00, pop};
    n_wr       = '0;
    for (int i = 0; i < NK; i++) begin
      if (tgl[i]) begin
        if (n_wr < free_slots) begin
          mem_d[wptr_q + PW'(n_wr)] = '{key: PW'(i), kind: ~ks_q[i], tstamp: timecnt};
          n_wr = n_wr + 3'd1;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
    wptr_d = wptr_q + PW'(n_wr);
    rptr_d = rptr_q + {1'b0, pop};
    occ_d  = occ_q - {2'b00, pop} + n_wr;
  end

  always_comb begin
    head      = mem_q[rptr_q];
    key_state = ks_q;
    hold_cnt  = hold_q;
    evt_valid = (occ_q != 3'd0);
    evt_key   = head.key;
    evt_type  = head.kind;
    evt_time  = head.tstamp;
    overflow  = ovf_q;
  end

endmodule
